// File: rtl/completion_arbiter_if.sv
// Completion-path bundle between the FU wrappers / ROB and the completion arbiter.
interface completion_arbiter_if #(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int NUM_PORTS    = 2
);
  logic [FU_COUNT-1:0]                       fu_done_valid;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]     fu_done_inst_id;
  logic [FU_COUNT-1:0]                       fu_stall;
  logic                                      rob_ready;
  logic [NUM_PORTS-1:0]                      rob_done_valid;
  logic [NUM_PORTS-1:0][INST_ID_BITS-1:0]    rob_done_inst_id;
  logic                                      overflow_err;

  // Environment side: FUs present completions, ROB accepts them.
  modport master (
    output fu_done_valid, fu_done_inst_id, rob_ready,
    input  fu_stall, rob_done_valid, rob_done_inst_id, overflow_err
  );

  // Arbiter side.
  modport slave (
    input  fu_done_valid, fu_done_inst_id, rob_ready,
    output fu_stall, rob_done_valid, rob_done_inst_id, overflow_err
  );
endinterface

// File: rtl/completion_arbiter.sv
// Completion arbiter: per-FU completion FIFOs drained round-robin into
// NUM_PORTS registered ROB completion ports, with FU back-pressure.
module completion_arbiter #(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int NUM_PORTS    = 2,
  parameter int FIFO_DEPTH   = 2
) (
  input logic clk,
  input logic rst,
  completion_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FU_W  = $clog2(FU_COUNT);
  localparam int GC_W  = $clog2(NUM_PORTS + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_C   = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FU_W:0]    FU_CNT_C  = (FU_W+1)'(FU_COUNT);
  localparam logic [FU_W-1:0]  FU_LAST   = FU_W'(FU_COUNT - 1);
  localparam logic [GC_W-1:0]  PORTS_C   = GC_W'(NUM_PORTS);

  logic [FU_COUNT-1:0]     grant;
  logic [FU_COUNT-1:0]     drop;
  logic [CNT_W-1:0]        count_vec [FU_COUNT];
  logic [INST_ID_BITS-1:0] head_data [FU_COUNT];

  logic [GC_W-1:0]         grant_cnt;
  logic [FU_W-1:0]         last_grant;
  logic [FU_W-1:0]         port_src [NUM_PORTS];
  logic [FU_W:0]           idx_sum;

  logic [FU_W-1:0]                     rr_ptr_reg;
  logic [NUM_PORTS-1:0]                valid_reg;
  logic [NUM_PORTS-1:0][INST_ID_BITS-1:0] id_reg;
  logic                                overflow_reg;

  // ---------------------------------------------------------------------
  // Per-FU circular completion FIFOs
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < FU_COUNT; gi++) begin : g_fifo
      logic [INST_ID_BITS-1:0] mem_reg [FIFO_DEPTH];
      logic [PTR_W-1:0]        head_reg;
      logic [PTR_W-1:0]        tail_reg;
      logic [CNT_W-1:0]        count_reg;
      logic                    push;
      logic                    pop;

      // A full FIFO still accepts a push when it is popped the same cycle.
      assign pop  = grant[gi];
      assign push = bus.fu_done_valid[gi] && ((count_reg != DEPTH_C) || pop);

      assign drop[gi]      = bus.fu_done_valid[gi] && (count_reg == DEPTH_C) && !pop;
      assign count_vec[gi] = count_reg;
      assign head_data[gi] = mem_reg[head_reg];
      assign bus.fu_stall[gi] = (count_reg >= STALL_C);

      // Storage writes; contents need no reset because count gates every read.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_reg[tail_reg] <= bus.fu_done_inst_id[gi];
        end
      end

      // Head/tail/count bookkeeping with modulo-depth wrap.
      always_ff @(posedge clk) begin
        if (rst) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
        end else begin
          if (push) begin
            tail_reg <= (tail_reg == PTR_LAST) ? '0 : tail_reg + 1'b1;
          end
          if (pop) begin
            head_reg <= (head_reg == PTR_LAST) ? '0 : head_reg + 1'b1;
          end
          if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
          end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Round-robin scan from rr_ptr granting the first NUM_PORTS non-empty FIFOs
  // ---------------------------------------------------------------------
  always_comb begin
    grant      = '0;
    grant_cnt  = '0;
    last_grant = rr_ptr_reg;
    idx_sum    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_src[p] = '0;
    end
    if (bus.rob_ready) begin
      for (int k = 0; k < FU_COUNT; k++) begin
        idx_sum = {1'b0, rr_ptr_reg} + (FU_W+1)'(k);
        if (idx_sum >= FU_CNT_C) begin
          idx_sum = idx_sum - FU_CNT_C;
        end
        if ((count_vec[idx_sum[FU_W-1:0]] != '0) && (grant_cnt < PORTS_C)) begin
          grant[idx_sum[FU_W-1:0]] = 1'b1;
          port_src[grant_cnt[$clog2(NUM_PORTS > 1 ? NUM_PORTS : 2)-1:0]] = idx_sum[FU_W-1:0];
          last_grant = idx_sum[FU_W-1:0];
          grant_cnt  = grant_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered ROB ports, round-robin pointer and sticky overflow flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      id_reg       <= '0;
      rr_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (|drop) begin
        overflow_reg <= 1'b1;
      end
      if (bus.rob_ready) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (GC_W'(p) < grant_cnt) begin
            valid_reg[p] <= 1'b1;
            id_reg[p]    <= head_data[port_src[p]];
          end else begin
            valid_reg[p] <= 1'b0;
            id_reg[p]    <= '0;
          end
        end
        if (grant_cnt != '0) begin
          rr_ptr_reg <= (last_grant == FU_LAST) ? '0 : last_grant + 1'b1;
        end
      end
    end
  end

  assign bus.rob_done_valid   = valid_reg;
  assign bus.rob_done_inst_id = id_reg;
  assign bus.overflow_err     = overflow_reg;

endmodule

// File: tb/tb_completion_arbiter.sv
// Bench for completion_arbiter: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_completion_arbiter;
  localparam int W  = 6;
  localparam int FU = 4;
  localparam int NP = 2;
  localparam int D  = 2;

  logic clk;
  logic rst;

  completion_arbiter_if #(.INST_ID_BITS(W), .FU_COUNT(FU), .NUM_PORTS(NP)) bus ();

  completion_arbiter #(
    .INST_ID_BITS(W), .FU_COUNT(FU), .NUM_PORTS(NP), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Stimulus for the upcoming edge.
  logic          s_rst;
  logic [FU-1:0] s_valid;
  int            s_id [FU];
  logic          s_ready;

  // Reference model state (what the DUT must show after the last edge).
  int m_q [FU][$];
  int m_rr;
  int m_v  [NP];
  int m_id [NP];
  int m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < FU; i++) m_q[i].delete();
    m_rr = 0;
    m_ovf = 0;
    for (int p = 0; p < NP; p++) begin
      m_v[p] = 0;
      m_id[p] = 0;
    end
  endtask

  // One clock edge worth of behaviour: grant up to NP fronts in RR order, then push.
  task automatic model_step();
    int ng;
    int last;
    int idx;
    if (s_rst) begin
      model_reset();
      return;
    end
    if (s_ready) begin
      ng = 0;
      last = -1;
      for (int p = 0; p < NP; p++) begin
        m_v[p] = 0;
        m_id[p] = 0;
      end
      for (int k = 0; k < FU; k++) begin
        idx = (m_rr + k) % FU;
        if (ng < NP && m_q[idx].size() > 0) begin
          m_v[ng]  = 1;
          m_id[ng] = m_q[idx].pop_front();
          ng++;
          last = idx;
        end
      end
      if (ng > 0) m_rr = (last + 1) % FU;
    end
    for (int i = 0; i < FU; i++) begin
      if (s_valid[i]) begin
        if (m_q[i].size() < D) m_q[i].push_back(s_id[i]);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("valid[%0d]", p), int'(bus.rob_done_valid[p]), m_v[p]);
      chk($sformatf("id[%0d]", p), int'(bus.rob_done_inst_id[p]), m_id[p]);
    end
    for (int i = 0; i < FU; i++) begin
      chk($sformatf("stall[%0d]", i), int'(bus.fu_stall[i]), (m_q[i].size() >= D - 1) ? 1 : 0);
    end
    chk("overflow_err", int'(bus.overflow_err), m_ovf);
    chk("rr_ptr", int'(dut.rr_ptr_reg), m_rr);
  endtask

  // Called at a negedge: drive stimulus, take the edge, update model, compare.
  task automatic cycle();
    rst = s_rst;
    bus.rob_ready = s_ready;
    for (int i = 0; i < FU; i++) begin
      bus.fu_done_valid[i]   = s_valid[i];
      bus.fu_done_inst_id[i] = W'(s_id[i]);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ready);
    s_rst = 1'b0;
    s_valid = '0;
    s_ready = ready;
    for (int i = 0; i < FU; i++) s_id[i] = 0;
  endtask

  task automatic do_reset();
    idle(1'b0);
    s_rst = 1'b1;
    cycle();
    s_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rob_ready = 1'b0;
    bus.fu_done_valid = '0;
    bus.fu_done_inst_id = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    // Reset values pinned literally.
    chk("reset valid0", int'(bus.rob_done_valid[0]), 0);
    chk("reset stall", int'(bus.fu_stall), 0);
    chk("reset overflow", int'(bus.overflow_err), 0);

    // Single completion from FU2.
    idle(1'b1); s_valid[2] = 1'b1; s_id[2] = 5; cycle();
    idle(1'b1); cycle();
    chk("t1 valid0", int'(bus.rob_done_valid[0]), 1);
    chk("t1 id0", int'(bus.rob_done_inst_id[0]), 5);
    chk("t1 valid1", int'(bus.rob_done_valid[1]), 0);
    chk("t1 rr", int'(dut.rr_ptr_reg), 3);

    // All four FUs at once.
    do_reset();
    idle(1'b1); s_valid = '1; for (int i = 0; i < FU; i++) s_id[i] = i + 1; cycle();
    idle(1'b1); cycle();
    chk("t2 c2 id0", int'(bus.rob_done_inst_id[0]), 1);
    chk("t2 c2 id1", int'(bus.rob_done_inst_id[1]), 2);
    idle(1'b1); cycle();
    chk("t2 c3 id0", int'(bus.rob_done_inst_id[0]), 3);
    chk("t2 c3 id1", int'(bus.rob_done_inst_id[1]), 4);
    chk("t2 rr", int'(dut.rr_ptr_reg), 0);
    idle(1'b1); cycle();
    chk("t2 c4 valid", int'(bus.rob_done_valid), 0);

    // Back-pressure with rob_ready low.
    do_reset();
    idle(1'b0); s_valid[0] = 1'b1; s_id[0] = 7; cycle();
    chk("t3 stall c1", int'(bus.fu_stall[0]), 1);
    idle(1'b0); s_valid[0] = 1'b1; s_id[0] = 8; cycle();
    for (int c = 0; c < 3; c++) begin idle(1'b0); cycle(); end
    chk("t3 held valid", int'(bus.rob_done_valid), 0);
    idle(1'b1); cycle();
    chk("t3 first id", int'(bus.rob_done_inst_id[0]), 7);
    chk("t3 first valid1", int'(bus.rob_done_valid[1]), 0);
    idle(1'b1); cycle();
    chk("t3 second id", int'(bus.rob_done_inst_id[0]), 8);
    chk("t3 stall drop", int'(bus.fu_stall[0]), 0);

    // Overflow: third completion into a full FIFO is dropped.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle(1'b0); s_valid[1] = 1'b1; s_id[1] = 9 + c; cycle();
    end
    chk("t4 overflow", int'(bus.overflow_err), 1);
    idle(1'b1); cycle();
    chk("t4 id a", int'(bus.rob_done_inst_id[0]), 9);
    idle(1'b1); cycle();
    chk("t4 id b", int'(bus.rob_done_inst_id[0]), 10);
    idle(1'b1); cycle();
    chk("t4 empty", int'(bus.rob_done_valid[0]), 0);
    chk("t4 sticky", int'(bus.overflow_err), 1);

    // FU0/FU1 alternating push while the other pops.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      idle(1'b1);
      s_valid[c % 2] = 1'b1;
      s_id[c % 2] = int'($urandom_range(0, 63));
      cycle();
    end
    chk("t5 no overflow", int'(bus.overflow_err), 0);

    // Random traffic with occasional stall violations, ROB stalls and resets.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      idle($urandom_range(0, 3) != 0);
      for (int i = 0; i < FU; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (!bus.fu_stall[i] || $urandom_range(0, 9) == 0) begin
            s_valid[i] = 1'b1;
            s_id[i] = int'($urandom_range(0, 63));
          end
        end
      end
      if ($urandom_range(0, 199) == 0) s_rst = 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
